// File: rtl/ctr_session_arbiter.sv
// ctr_session_arbiter
//   Round-robin arbiter that shares one up/down counter game between
//   NUM_PLAYERS requesters. For each granted player it loads the player's
//   initial value with a one-cycle INIT pulse. It then drives the player's
//   count mode until the counter reports WINNER or LOSER, or until the run
//   length reaches MAX_RUN. The session outcome is returned with a one-cycle
//   done pulse.
//
// Ports
//   clock, reset_n       clock; asynchronous active-low reset
//   req                  per-player level request, held until granted
//   req_control          per-player 2-bit count mode, player i at [2i+1:2i]
//   req_init             per-player initial value, packed like req_control
//   gnt                  one-hot grant, high for the whole session
//   done                 one-hot, one-cycle session-complete pulse
//   result               00 timeout, 01 loser, 10 winner (valid with done)
//   busy                 high whenever the arbiter is not idle
//   ctr_init             counter INIT load pulse
//   ctr_initial_value    counter initial_value
//   ctr_control          counter control
//   ctr_winner/ctr_loser counter event pulses
module ctr_session_arbiter #(
  parameter int unsigned NUM_PLAYERS  = 4,
  parameter int unsigned COUNTER_SIZE = 3,
  parameter int unsigned MAX_RUN      = 16
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [NUM_PLAYERS-1:0]              req,
  input  logic [2*NUM_PLAYERS-1:0]            req_control,
  input  logic [COUNTER_SIZE*NUM_PLAYERS-1:0] req_init,
  output logic [NUM_PLAYERS-1:0]              gnt,
  output logic [NUM_PLAYERS-1:0]              done,
  output logic [1:0]                          result,
  output logic                                busy,
  output logic                                ctr_init,
  output logic [COUNTER_SIZE-1:0]             ctr_initial_value,
  output logic [1:0]                          ctr_control,
  input  logic                                ctr_winner,
  input  logic                                ctr_loser
);

  localparam int unsigned IW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam logic [7:0]  RUN_LAST    = 8'(MAX_RUN - 1);
  localparam logic [1:0]  RES_TIMEOUT = 2'b00;
  localparam logic [1:0]  RES_LOSER   = 2'b01;
  localparam logic [1:0]  RES_WINNER  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_RUN    = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t                  state;
  logic [IW-1:0]           rr_ptr;
  logic [IW-1:0]           cur_idx;
  logic [1:0]              lat_control;
  logic [COUNTER_SIZE-1:0] lat_init;
  logic [1:0]              pend_result;
  logic [7:0]              run_cnt;

  // Per-player views of the packed request fields.
  logic [1:0]              ctl_arr  [NUM_PLAYERS];
  logic [COUNTER_SIZE-1:0] init_arr [NUM_PLAYERS];

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_unpack
    assign ctl_arr[g]  = req_control[2*g +: 2];
    assign init_arr[g] = req_init[COUNTER_SIZE*g +: COUNTER_SIZE];
  end

  // Round-robin pick: first requester strictly after rr_ptr, wrapping.
  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  always_comb begin
    logic [IW-1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_PLAYERS; k++) begin
      cand = IW'((32'(rr_ptr) + k) % NUM_PLAYERS);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      rr_ptr            <= IW'(NUM_PLAYERS - 1);
      cur_idx           <= '0;
      lat_control       <= '0;
      lat_init          <= '0;
      pend_result       <= RES_TIMEOUT;
      run_cnt           <= '0;
      gnt               <= '0;
      done              <= '0;
      result            <= RES_TIMEOUT;
      busy              <= 1'b0;
      ctr_init          <= 1'b0;
      ctr_initial_value <= '0;
      ctr_control       <= '0;
    end else begin
      ctr_init <= 1'b0;
      done     <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            cur_idx       <= pick_idx;
            lat_control   <= ctl_arr[pick_idx];
            lat_init      <= init_arr[pick_idx];
            gnt[pick_idx] <= 1'b1;
            busy          <= 1'b1;
            state         <= S_LOAD;
          end
        end
        S_LOAD: begin
          ctr_init          <= 1'b1;
          ctr_initial_value <= lat_init;
          ctr_control       <= lat_control;
          run_cnt           <= '0;
          state             <= S_RUN;
        end
        S_RUN: begin
          run_cnt <= run_cnt + 8'd1;
          // Loser beats winner, and any event beats the timeout.
          if (ctr_loser) begin
            pend_result <= RES_LOSER;
            state       <= S_REPORT;
          end else if (ctr_winner) begin
            pend_result <= RES_WINNER;
            state       <= S_REPORT;
          end else if (run_cnt == RUN_LAST) begin
            pend_result <= RES_TIMEOUT;
            state       <= S_REPORT;
          end
        end
        S_REPORT: begin
          gnt         <= '0;
          done        <= gnt;
          result      <= pend_result;
          rr_ptr      <= cur_idx;
          ctr_control <= '0;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctr_session_arbiter.sv
module tb_ctr_session_arbiter;
  localparam int NP = 4;
  localparam int CS = 3;
  localparam int MR = 16;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [NP-1:0]   req;
  logic [2*NP-1:0] req_control;
  logic [CS*NP-1:0] req_init;
  logic [NP-1:0]   gnt, done;
  logic [1:0]      result;
  logic            busy, ctr_init;
  logic [CS-1:0]   ctr_initial_value;
  logic [1:0]      ctr_control;
  logic            ctr_winner, ctr_loser;

  int checks = 0;
  int errors = 0;
  int m_rr   = NP - 1;
  int served [NP];

  always #5 clock = ~clock;

  ctr_session_arbiter #(
    .NUM_PLAYERS (NP),
    .COUNTER_SIZE(CS),
    .MAX_RUN     (MR)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req              (req),
    .req_control      (req_control),
    .req_init         (req_init),
    .gnt              (gnt),
    .done             (done),
    .result           (result),
    .busy             (busy),
    .ctr_init         (ctr_init),
    .ctr_initial_value(ctr_initial_value),
    .ctr_control      (ctr_control),
    .ctr_winner       (ctr_winner),
    .ctr_loser        (ctr_loser)
  );

  // Reference arbitration: first requester after the last served player.
  function automatic int model_pick(input logic [NP-1:0] mask);
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (m_rr + k) % NP;
      if (mask[p]) return p;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ev_kind: 0 none, 1 loser, 2 winner, 3 both
  task automatic run_session(input logic [NP-1:0] mask, input int ev_cycle,
                             input int ev_kind, input bit noise, input bit drop,
                             input bit keep, input bit fixv, input logic [1:0] f_ctl,
                             input logic [CS-1:0] f_ini, input string tag);
    int            exp_p, len;
    logic [NP-1:0] exp_oh;
    logic [1:0]    ctl, exp_res;
    logic [CS-1:0] ini;
    bit            ev_on;
    exp_p  = model_pick(mask);
    exp_oh = '0;
    exp_oh[exp_p] = 1'b1;
    req         = mask;
    req_control = 8'($urandom);
    req_init    = 12'($urandom);
    if (fixv) begin
      req_control[2*exp_p +: 2]  = f_ctl;
      req_init[CS*exp_p +: CS]   = f_ini;
    end
    ctl   = req_control[2*exp_p +: 2];
    ini   = req_init[CS*exp_p +: CS];
    ev_on = (ev_kind != 0) && (ev_cycle >= 1) && (ev_cycle <= MR);
    if (ev_on) begin
      len     = ev_cycle;
      exp_res = (ev_kind == 2) ? 2'b10 : 2'b01;
    end else begin
      len     = MR;
      exp_res = 2'b00;
    end

    step();  // LOAD cycle
    checks++;
    if ({gnt, busy, ctr_init, done} !== {exp_oh, 1'b1, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL %s grant: gnt=%b busy=%b init=%b done=%b, expected gnt=%b busy=1 init=0 done=0000",
               tag, gnt, busy, ctr_init, done, exp_oh);
    end
    for (int i = 0; i < NP; i++) if (gnt[i]) served[i]++;
    req_control = 8'($urandom);
    req_init    = 12'($urandom);
    if (drop) req = '0;
    ctr_winner = noise ? 1'($urandom) : 1'b0;
    ctr_loser  = noise ? 1'($urandom) : 1'b0;

    for (int j = 1; j <= len; j++) begin
      step();
      ctr_winner = 1'b0;
      ctr_loser  = 1'b0;
      checks++;
      if ({gnt, busy, ctr_init, ctr_control, done} !==
          {exp_oh, 1'b1, (j == 1), ctl, 4'b0000}) begin
        errors++;
        $display("FAIL %s run%0d: gnt=%b busy=%b init=%b ctl=%b done=%b, expected gnt=%b busy=1 init=%b ctl=%b done=0000",
                 tag, j, gnt, busy, ctr_init, ctr_control, done, exp_oh, (j == 1), ctl);
      end
      if (j == 1) begin
        checks++;
        if (ctr_initial_value !== ini) begin
          errors++;
          $display("FAIL %s init_value: got %0d, expected %0d", tag, ctr_initial_value, ini);
        end
      end
      if (ev_on && j == ev_cycle) begin
        ctr_loser  = (ev_kind == 1) || (ev_kind == 3);
        ctr_winner = (ev_kind == 2) || (ev_kind == 3);
      end
    end

    step();  // REPORT cycle
    ctr_winner = noise ? 1'($urandom) : 1'b0;
    ctr_loser  = noise ? 1'($urandom) : 1'b0;
    checks++;
    if ({gnt, busy, done} !== {exp_oh, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL %s report: gnt=%b busy=%b done=%b, expected gnt=%b busy=1 done=0000",
               tag, gnt, busy, done, exp_oh);
    end

    step();  // done pulse visible
    ctr_winner = 1'b0;
    ctr_loser  = 1'b0;
    checks++;
    if ({done, result, gnt, busy, ctr_control, ctr_init} !==
        {exp_oh, exp_res, 4'b0000, 1'b0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL %s done: done=%b result=%b gnt=%b busy=%b ctl=%b init=%b, expected done=%b result=%b gnt=0000 busy=0 ctl=00 init=0",
               tag, done, result, gnt, busy, ctr_control, ctr_init, exp_oh, exp_res);
    end
    m_rr = exp_p;
    if (!keep) req = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = '0; req_control = '0; req_init = '0;
    ctr_winner = 1'b0; ctr_loser = 1'b0;
    step(); step();
    checks++;
    if ({gnt, done, result, busy, ctr_init, ctr_initial_value, ctr_control} !== '0) begin
      errors++;
      $display("FAIL reset: gnt=%b done=%b result=%b busy=%b init=%b val=%0d ctl=%b, expected all zero",
               gnt, done, result, busy, ctr_init, ctr_initial_value, ctr_control);
    end
    @(negedge clock);
    reset_n = 1'b1;
    m_rr = NP - 1;
  endtask

  task automatic test_first_session();
    // winner on the 3rd RUN cycle, init 5, mode +1
    run_session(4'b0001, 3, 2, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'd5, "first");
    step();
    checks++;
    if (done !== 4'b0000) begin
      errors++;
      $display("FAIL done_width: done=%b, expected 0000", done);
    end
  endtask

  task automatic test_event_priority();
    run_session(4'b1000, 5, 3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, "both_events");
    run_session(4'b0110, MR, 2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, "win_at_timeout");
    run_session(4'b1001, MR, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, "lose_at_timeout");
    run_session(4'b0100, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, "timeout");
    run_session(4'b0011, MR + 1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, "late_event");
  endtask

  task automatic test_starvation();
    for (int i = 0; i < NP; i++) served[i] = 0;
    for (int s = 0; s < 2 * NP; s++)
      run_session(4'b1111, int'($urandom_range(1, MR + 2)), int'($urandom_range(0, 3)),
                  1'b1, 1'b0, (s != 2 * NP - 1), 1'b0, 2'b00, 3'd0, "starve");
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (served[i] != 2) begin
        errors++;
        $display("FAIL starve_count p%0d: served %0d, expected 2", i, served[i]);
      end
    end
  endtask

  task automatic test_single();
    for (int s = 0; s < 3; s++)
      run_session(4'b0010, int'($urandom_range(1, 6)), 2, 1'b0, 1'b0, (s != 2),
                  1'b0, 2'b00, 3'd0, "single");
  endtask

  task automatic test_drop();
    run_session(4'b1010, 4, 1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0, "drop_req");
  endtask

  task automatic test_random();
    for (int s = 0; s < 24; s++) begin
      logic [NP-1:0] m;
      m = 4'($urandom_range(1, 15));
      run_session(m, int'($urandom_range(1, MR + 2)), int'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 2'b00, 3'd0, "random");
    end
    req = '0;
    step();
  endtask

  task automatic test_reset_mid();
    req = 4'b0001;
    step(); step(); step();  // LOAD, RUN1, RUN2
    req = '0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({gnt, done, result, busy, ctr_init, ctr_control} !== '0) begin
      errors++;
      $display("FAIL reset_mid: gnt=%b done=%b result=%b busy=%b init=%b ctl=%b, expected all zero",
               gnt, done, result, busy, ctr_init, ctr_control);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (done !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mid_done c%0d: done=%b, expected 0000", c, done);
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
    m_rr = NP - 1;
    run_session(4'b0100, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, "after_reset");
    m_rr = NP - 1;
    reset_n = 1'b0;
    #1;
    @(negedge clock);
    reset_n = 1'b1;
    run_session(4'b1111, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, "rr_reset");
  endtask

  initial begin
    for (int i = 0; i < NP; i++) served[i] = 0;
    test_reset();
    test_first_session();
    test_event_priority();
    test_starvation();
    test_single();
    test_drop();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "time limit");
  end

endmodule
